// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle between a pixel-stream producer/consumer and sync_fifo_flex.
// The master side drives the write and read requests; the FIFO is the slave side.
interface sync_fifo_flex_if #(
  parameter int unsigned C_FIFO_WIDTH = 8,
  parameter int unsigned C_FIFO_DEPTH = 16
);
  localparam int unsigned CntW = $clog2(C_FIFO_DEPTH) + 1;

  logic                    wr_en;
  logic [C_FIFO_WIDTH-1:0] din;
  logic                    full;
  logic                    almost_full;
  logic                    overflow;
  logic                    rd_en;
  logic [C_FIFO_WIDTH-1:0] dout;
  logic                    valid;
  logic                    empty;
  logic                    almost_empty;
  logic                    underflow;
  logic [CntW-1:0]         data_count;

  modport master (
    output wr_en, din, rd_en,
    input  full, almost_full, overflow, dout, valid, empty, almost_empty, underflow,
           data_count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, almost_full, overflow, dout, valid, empty, almost_empty, underflow,
           data_count
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, error pulses and an exact occupancy count.
module sync_fifo_flex #(
  parameter int unsigned C_FIFO_WIDTH    = 8,
  parameter int unsigned C_FIFO_DEPTH    = 16,
  parameter int unsigned C_FWFT          = 0,
  parameter int unsigned C_AFULL_THRESH  = C_FIFO_DEPTH - 2,
  parameter int unsigned C_AEMPTY_THRESH = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flex_if.slave fifo
);

  localparam int unsigned PtrW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(C_FIFO_DEPTH) + 1;

  logic [C_FIFO_WIDTH-1:0] mem [C_FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q, afull_q, aempty_q;
  logic            overflow_q, underflow_q;
  logic            wr_acc, rd_acc;

  // Explicit wrap compare keeps non-power-of-2 depths correct.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(C_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_acc   = fifo.wr_en & ~full_q;
    rd_acc   = fifo.rd_en & ~empty_q;
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next count so they move on the same edge as data_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CntW'(C_FIFO_DEPTH));
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= CntW'(C_AFULL_THRESH));
      aempty_q    <= (count_d <= CntW'(C_AEMPTY_THRESH));
      overflow_q  <= fifo.wr_en & full_q;
      underflow_q <= fifo.rd_en & empty_q;
    end
  end

  // Storage is never reset; a reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= fifo.din;
    end
  end

  if (C_FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while empty so reset presents dout = 0.
    assign fifo.dout  = empty_q ? '0 : mem[rd_ptr_q];
    assign fifo.valid = ~empty_q;
  end else begin : g_std
    logic [C_FIFO_WIDTH-1:0] dout_q;
    logic                    valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= mem[rd_ptr_q];
        end
      end
    end

    assign fifo.dout  = dout_q;
    assign fifo.valid = valid_q;
  end

  assign fifo.full         = full_q;
  assign fifo.almost_full  = afull_q;
  assign fifo.overflow     = overflow_q;
  assign fifo.empty        = empty_q;
  assign fifo.almost_empty = aempty_q;
  assign fifo.underflow    = underflow_q;
  assign fifo.data_count   = count_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-mode depth-16 instance and an FWFT depth-5
// instance, each checked every cycle against a queue model plus directed literal checks.
module tb_sync_fifo_flex;

  localparam int unsigned SD  = 16;
  localparam int unsigned SAF = 14;
  localparam int unsigned SAE = 2;
  localparam int unsigned FD  = 5;
  localparam int unsigned FAF = 3;
  localparam int unsigned FAE = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.C_FIFO_WIDTH(8), .C_FIFO_DEPTH(SD)) if_s ();
  sync_fifo_flex_if #(.C_FIFO_WIDTH(8), .C_FIFO_DEPTH(FD)) if_f ();

  sync_fifo_flex #(
    .C_FIFO_WIDTH(8), .C_FIFO_DEPTH(SD), .C_FWFT(0),
    .C_AFULL_THRESH(SAF), .C_AEMPTY_THRESH(SAE)
  ) dut_s (
    .clk(clk), .rst(rst), .fifo(if_s.slave)
  );

  sync_fifo_flex #(
    .C_FIFO_WIDTH(8), .C_FIFO_DEPTH(FD), .C_FWFT(1),
    .C_AFULL_THRESH(FAF), .C_AEMPTY_THRESH(FAE)
  ) dut_f (
    .clk(clk), .rst(rst), .fifo(if_f.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as queues, plus the registered read/error outputs.
  logic [7:0] qs[$];
  logic [7:0] qf[$];
  logic [7:0] ms_dout;
  bit ms_valid, ms_ovf, ms_unf, mf_ovf, mf_unf;
  bit live = 1'b0;

  always @(posedge clk) begin
    int unsigned ns, nf;
    ns = qs.size();
    nf = qf.size();
    if (rst) begin
      qs.delete();
      qf.delete();
      ms_dout  = 8'h00;
      ms_valid = 1'b0;
      ms_ovf   = 1'b0;
      ms_unf   = 1'b0;
      mf_ovf   = 1'b0;
      mf_unf   = 1'b0;
      live     = 1'b1;
    end else begin
      ms_ovf = if_s.wr_en && (ns == SD);
      ms_unf = if_s.rd_en && (ns == 0);
      if (if_s.rd_en && ns != 0) begin
        ms_dout  = qs.pop_front();
        ms_valid = 1'b1;
      end else begin
        ms_valid = 1'b0;
      end
      if (if_s.wr_en && ns != SD) qs.push_back(if_s.din);

      mf_ovf = if_f.wr_en && (nf == FD);
      mf_unf = if_f.rd_en && (nf == 0);
      if (if_f.rd_en && nf != 0) void'(qf.pop_front());
      if (if_f.wr_en && nf != FD) qf.push_back(if_f.din);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("s_count", 32'(if_s.data_count), qs.size());
      chk("s_full", 32'(if_s.full), 32'(qs.size() == SD));
      chk("s_empty", 32'(if_s.empty), 32'(qs.size() == 0));
      chk("s_afull", 32'(if_s.almost_full), 32'(qs.size() >= SAF));
      chk("s_aempty", 32'(if_s.almost_empty), 32'(qs.size() <= SAE));
      chk("s_ovf", 32'(if_s.overflow), 32'(ms_ovf));
      chk("s_unf", 32'(if_s.underflow), 32'(ms_unf));
      chk("s_valid", 32'(if_s.valid), 32'(ms_valid));
      chk("s_dout", 32'(if_s.dout), 32'(ms_dout));

      chk("f_count", 32'(if_f.data_count), qf.size());
      chk("f_full", 32'(if_f.full), 32'(qf.size() == FD));
      chk("f_empty", 32'(if_f.empty), 32'(qf.size() == 0));
      chk("f_afull", 32'(if_f.almost_full), 32'(qf.size() >= FAF));
      chk("f_aempty", 32'(if_f.almost_empty), 32'(qf.size() <= FAE));
      chk("f_ovf", 32'(if_f.overflow), 32'(mf_ovf));
      chk("f_unf", 32'(if_f.underflow), 32'(mf_unf));
      chk("f_valid", 32'(if_f.valid), 32'(qf.size() != 0));
      chk("f_dout", 32'(if_f.dout), (qf.size() != 0) ? 32'(qf[0]) : 32'h0);
    end
  end

  task automatic drive(input bit sw, input bit sr, input logic [7:0] sdin,
                       input bit fw, input bit fr, input logic [7:0] fdin);
    if_s.wr_en = sw;
    if_s.rd_en = sr;
    if_s.din   = sdin;
    if_f.wr_en = fw;
    if_f.rd_en = fr;
    if_f.din   = fdin;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(if_s.data_count), 0);
    chk("rst_empty", 32'(if_s.empty), 1);
    chk("rst_aempty", 32'(if_s.almost_empty), 1);
    chk("rst_full", 32'(if_s.full), 0);
    chk("rst_valid", 32'(if_s.valid), 0);
    chk("rst_dout", 32'(if_s.dout), 0);

    // Standard fill and drain.
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, i[7:0], 0, 0, 8'h00);
      tick();
      if (i == 13) chk("t1_afull_at13", 32'(if_s.almost_full), 0);
      if (i == 14) chk("t1_afull_at14", 32'(if_s.almost_full), 1);
    end
    chk("t1_count16", 32'(if_s.data_count), 16);
    chk("t1_full", 32'(if_s.full), 1);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 8'h00, 0, 0, 8'h00);
      tick();
      chk("t1_dout", 32'(if_s.dout), i);
      chk("t1_valid", 32'(if_s.valid), 1);
    end
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    chk("t1_valid_end", 32'(if_s.valid), 0);
    chk("t1_empty_end", 32'(if_s.empty), 1);

    // Full boundary: concurrent write is rejected, read proceeds.
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(8'h20 + i), 0, 0, 8'h00);
      tick();
    end
    drive(1, 1, 8'hAA, 0, 0, 8'h00);
    tick();
    chk("t2_ovf", 32'(if_s.overflow), 1);
    chk("t2_count", 32'(if_s.data_count), 15);
    chk("t2_dout", 32'(if_s.dout), 32'h20);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    chk("t2_ovf_clear", 32'(if_s.overflow), 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 8'h00, 0, 0, 8'h00);
      tick();
    end
    chk("t2_last", 32'(if_s.dout), 32'h2F);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    tick();

    // Empty boundary: read rejected, write accepted.
    drive(1, 1, 8'h55, 0, 0, 8'h00);
    tick();
    chk("t3_unf", 32'(if_s.underflow), 1);
    chk("t3_count", 32'(if_s.data_count), 1);
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    tick();
    chk("t3_dout", 32'(if_s.dout), 32'h55);
    chk("t3_valid", 32'(if_s.valid), 1);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    tick();

    // FWFT depth 5: fall-through latency and pointer wrap.
    drive(0, 0, 8'h00, 1, 0, 8'h11);
    tick();
    chk("t4_dout", 32'(if_f.dout), 32'h11);
    chk("t4_valid", 32'(if_f.valid), 1);
    drive(0, 0, 8'h00, 0, 1, 8'h00);
    tick();
    chk("t4_empty", 32'(if_f.empty), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 1, 0, 8'(8'h30 + i));
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 8'h00, 1, 1, 8'(8'h33 + i));
      tick();
    end
    chk("t4_head", 32'(if_f.dout), 32'h3C);
    chk("t4_count", 32'(if_f.data_count), 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 0, 1, 8'h00);
      tick();
    end
    chk("t4_drained", 32'(if_f.empty), 1);

    // Thresholds 3 / 1.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 8'h00, 1, 0, i[7:0]);
      tick();
      if (i == 1) chk("t5_aempty1", 32'(if_f.almost_empty), 1);
      if (i == 2) chk("t5_aempty2", 32'(if_f.almost_empty), 0);
      if (i == 2) chk("t5_afull2", 32'(if_f.almost_full), 0);
      if (i == 3) chk("t5_afull3", 32'(if_f.almost_full), 1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 0, 1, 8'h00);
      tick();
    end

    // Reset mid-stream.
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 8'(8'h40 + i), 0, 0, 8'h00);
      tick();
    end
    chk("t6_count7", 32'(if_s.data_count), 7);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_count", 32'(if_s.data_count), 0);
    chk("t6_empty", 32'(if_s.empty), 1);
    chk("t6_valid", 32'(if_s.valid), 0);
    chk("t6_dout", 32'(if_s.dout), 0);
    drive(1, 0, 8'h77, 0, 0, 8'h00);
    tick();
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    tick();
    chk("t6_new", 32'(if_s.dout), 32'h77);

    // Random traffic with fill/drain biased phases and rare resets.
    for (int c = 0; c < 3000; c++) begin
      int unsigned pw;
      pw  = ((c / 400) % 2 == 0) ? 70 : 30;
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 8'($urandom),
            $urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 8'($urandom));
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
